// File: rtl/rhd_pkg.sv
// rhd_pkg: shared defaults, channel width and capture FSM states for the RHD MISO capture block
package rhd_pkg;
  localparam int WORD_W_DEF = 16;
  localparam int RHD_CHANNEL_W = 8;
  typedef enum logic [1:0] {IDLE, FRAME, DRAIN, PUSH} state_t;
endpackage

// File: rtl/rhd_miso_port.sv
// rhd_miso_port: per-port MISO shift register with saturating bit counter; RHD_DDR_EN adds a falling-edge twin
module rhd_miso_port import rhd_pkg::*; #(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  input  logic              stb,
  input  logic              miso,
`ifdef RHD_DDR_EN
  input  logic              stb_f,
  output logic [WORD_W-1:0] word_f,
`endif
  output logic [WORD_W-1:0] word,
  output logic              err
);
  localparam int CW = $clog2(WORD_W + 2);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      word <= '0;
      cnt  <= '0;
    end else if (clr) begin
      word <= '0;
      cnt  <= '0;
    end else if (stb) begin
      word <= {word[WORD_W-2:0], miso};
      cnt  <= (cnt == CW'(WORD_W + 1)) ? cnt : cnt + 1'b1;
    end
`ifdef RHD_DDR_EN
  logic [CW-1:0] cnt_f;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      word_f <= '0;
      cnt_f  <= '0;
    end else if (clr) begin
      word_f <= '0;
      cnt_f  <= '0;
    end else if (stb_f) begin
      word_f <= {word_f[WORD_W-2:0], miso};
      cnt_f  <= (cnt_f == CW'(WORD_W + 1)) ? cnt_f : cnt_f + 1'b1;
    end
  assign err = (cnt != CW'(WORD_W)) || (cnt_f != CW'(WORD_W));
`else
  assign err = cnt != CW'(WORD_W);
`endif
endmodule

// File: rtl/rhd_miso_capture.sv
// rhd_miso_capture: oversampled multi-port RHD MISO capture with per-port delay taps and a one-deep output register
// Define RHD_DDR_EN to also capture on SCLK falls (adds out_data_ddr).
module rhd_miso_capture import rhd_pkg::*; #(
  parameter int NUM_PORTS = 32,
  parameter int WORD_W    = WORD_W_DEF,
  parameter int OFFSET_W  = 6
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          SCLK,
  input  logic                          CS,
  input  logic [NUM_PORTS-1:0]          MISO,
  input  logic [NUM_PORTS*OFFSET_W-1:0] oversample_offset,
  input  logic [RHD_CHANNEL_W-1:0]      channel_in,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [NUM_PORTS*WORD_W-1:0]   out_data,
`ifdef RHD_DDR_EN
  output logic [NUM_PORTS*WORD_W-1:0]   out_data_ddr,
`endif
  output logic [RHD_CHANNEL_W-1:0]      out_channel,
  output logic [NUM_PORTS-1:0]          out_err,
  output logic                          overflow
);
  localparam int MAX_OFF = 2**OFFSET_W - 1;
  state_t                        state;
  logic                          sclk_q, cs_q;
  logic [MAX_OFF-1:0]            dly;
  logic [MAX_OFF:0]              tap;
  logic [OFFSET_W-1:0]           dcnt;
  logic [RHD_CHANNEL_W-1:0]      chan;
  logic [NUM_PORTS*WORD_W-1:0]   words;
  logic [NUM_PORTS-1:0]          err;
  logic                          clr, load;
  // Strobes only originate in FRAME so a frame begun during DRAIN/PUSH cannot pollute the record
  assign tap  = {dly, SCLK & ~sclk_q & ~CS & (state == FRAME)};
  assign clr  = (state == IDLE) && cs_q && !CS;
  assign load = (state == PUSH) && (!out_valid || out_ready);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      sclk_q <= 1'b0;
      cs_q   <= 1'b1;
      dly    <= '0;
    end else begin
      sclk_q <= SCLK;
      cs_q   <= CS;
      dly    <= tap[MAX_OFF-1:0];
    end
`ifdef RHD_DDR_EN
  logic [MAX_OFF-1:0]          dly_f;
  logic [MAX_OFF:0]            tap_f;
  logic [NUM_PORTS*WORD_W-1:0] words_f;
  assign tap_f = {dly_f, ~SCLK & sclk_q & ~CS & (state == FRAME)};
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      dly_f        <= '0;
      out_data_ddr <= '0;
    end else begin
      dly_f        <= tap_f[MAX_OFF-1:0];
      out_data_ddr <= load ? words_f : out_data_ddr;
    end
`endif
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    rhd_miso_port #(.WORD_W(WORD_W)) u_port (
      .clk  (clk),
      .rstn (rstn),
      .clr  (clr),
      .stb  (tap[oversample_offset[p*OFFSET_W +: OFFSET_W]]),
      .miso (MISO[p]),
`ifdef RHD_DDR_EN
      .stb_f  (tap_f[oversample_offset[p*OFFSET_W +: OFFSET_W]]),
      .word_f (words_f[p*WORD_W +: WORD_W]),
`endif
      .word (words[p*WORD_W +: WORD_W]),
      .err  (err[p])
    );
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state       <= IDLE;
      dcnt        <= '0;
      chan        <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_channel <= '0;
      out_err     <= '0;
      overflow    <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        IDLE:    if (clr) begin
                   state <= FRAME;
                   chan  <= channel_in;
                 end
        FRAME:   if (CS) state <= DRAIN;
        DRAIN:   begin
                   dcnt  <= dcnt + 1'b1;
                   state <= (dcnt == '1) ? PUSH : DRAIN;
                 end
        PUSH:    begin
                   state <= IDLE;
                   if (load) begin
                     out_valid   <= 1'b1;
                     out_data    <= words;
                     out_channel <= chan;
                     out_err     <= err;
                   end else overflow <= 1'b1;
                 end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_rhd_miso_capture.sv
// tb_rhd_miso_capture: directed checks of capture, latency, short frames, overflow, reset and ignored frames
module tb_rhd_miso_capture;
  logic        clk = 1'b0;
  logic        rstn, SCLK, CS, out_ready, out_valid, overflow;
  logic [3:0]  MISO, out_err;
  logic [23:0] oversample_offset;
  logic [7:0]  channel_in, out_channel;
  logic [63:0] out_data;
`ifdef RHD_DDR_EN
  logic [63:0] out_data_ddr;
`endif
  int errors = 0;
  int checks = 0;
  int n;
  localparam logic [63:0] SET1  = {16'h0001, 16'hFFFF, 16'h1234, 16'hA5C3};
  localparam logic [63:0] SET2  = {16'h7FFE, 16'h8000, 16'hBEEF, 16'h0F0F};
  localparam logic [63:0] SHORT = {16'h0000, 16'h7FFF, 16'h091A, 16'h52E1};
  localparam logic [63:0] FALLD = {4{16'h5A5A}};

  rhd_miso_capture #(.NUM_PORTS(4), .WORD_W(16), .OFFSET_W(6)) dut (
    .clk               (clk),
    .rstn              (rstn),
    .SCLK              (SCLK),
    .CS                (CS),
    .MISO              (MISO),
    .oversample_offset (oversample_offset),
    .channel_in        (channel_in),
    .out_ready         (out_ready),
    .out_valid         (out_valid),
    .out_data          (out_data),
`ifdef RHD_DDR_EN
    .out_data_ddr      (out_data_ddr),
`endif
    .out_channel       (out_channel),
    .out_err           (out_err),
    .overflow          (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic bits(input int nb, input logic [63:0] rd, input logic [63:0] fd);
    for (int b = 0; b < nb; b++) begin
      for (int p = 0; p < 4; p++) MISO[p] = rd[p*16 + 15 - b];
      tick(2);
      SCLK = 1'b1;
      tick(70);
      for (int p = 0; p < 4; p++) MISO[p] = fd[p*16 + 15 - b];
      tick(2);
      SCLK = 1'b0;
      tick(70);
    end
  endtask

  task automatic frame(input int nb, input logic [7:0] ch, input logic [63:0] rd, input logic [63:0] fd);
    CS = 1'b0;
    channel_in = ch;
    tick(4);
    channel_in = 8'hEE;
    bits(nb, rd, fd);
    tick(2);
    CS = 1'b1;
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    while (!out_valid && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    check("valid_seen", {63'd0, out_valid}, 64'd1);
  endtask

  initial begin
    rstn = 1'b0; SCLK = 1'b0; CS = 1'b1; MISO = '0; out_ready = 1'b0; channel_in = '0;
    oversample_offset = {6'd63, 6'd5, 6'd1, 6'd0};
    tick(3);
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_data", out_data, 64'd0);
    check("rst_chan", {56'd0, out_channel}, 64'd0);
    check("rst_err", {60'd0, out_err}, 64'd0);
    check("rst_ovf", {63'd0, overflow}, 64'd0);
    rstn = 1'b1;
    tick(3);
    // full frame, latency from CS rise
    frame(16, 8'h11, SET1, FALLD);
    wait_valid(n);
    check("latency", 64'(n), 64'd66);
    check("data1", out_data, SET1);
    check("err1", {60'd0, out_err}, 64'd0);
    check("chan1", {56'd0, out_channel}, 64'h11);
    check("ovf1", {63'd0, overflow}, 64'd0);
`ifdef RHD_DDR_EN
    check("ddr1", out_data_ddr, FALLD);
`endif
    out_ready = 1'b1;
    tick(1);
    check("hs1", {63'd0, out_valid}, 64'd0);
    out_ready = 1'b0;
    // short frame: 15 bits
    frame(15, 8'h22, SET1, FALLD);
    wait_valid(n);
    check("short_err", {60'd0, out_err}, 64'hF);
    check("short_data", out_data, SHORT);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    // two frames, consumer stalled
    frame(16, 8'h33, SET1, FALLD);
    wait_valid(n);
    check("ovfA_data", out_data, SET1);
    frame(16, 8'h44, SET2, FALLD);
    tick(80);
    check("ovf_hold_data", out_data, SET1);
    check("ovf_hold_chan", {56'd0, out_channel}, 64'h33);
    check("ovf_flag", {63'd0, overflow}, 64'd1);
    check("ovf_valid", {63'd0, out_valid}, 64'd1);
    out_ready = 1'b1;
    tick(1);
    check("ovf_hs", {63'd0, out_valid}, 64'd0);
    tick(5);
    check("ovf_once", {63'd0, out_valid}, 64'd0);
    check("ovf_sticky", {63'd0, overflow}, 64'd1);
    // reset mid-frame
    CS = 1'b0;
    channel_in = 8'h77;
    tick(4);
    bits(8, SET2, FALLD);
    rstn = 1'b0;
    tick(1);
    check("mrst_valid", {63'd0, out_valid}, 64'd0);
    check("mrst_data", out_data, 64'd0);
    check("mrst_chan", {56'd0, out_channel}, 64'd0);
    check("mrst_ovf", {63'd0, overflow}, 64'd0);
    CS = 1'b1;
    rstn = 1'b1;
    tick(3);
    frame(16, 8'h2A, SET2, FALLD);
    wait_valid(n);
    check("mrst2_data", out_data, SET2);
    check("mrst2_chan", {56'd0, out_channel}, 64'h2A);
    check("mrst2_err", {60'd0, out_err}, 64'd0);
    tick(2);
    out_ready = 1'b0;
    // CS fall during DRAIN is ignored
    frame(16, 8'h55, SET1, FALLD);
    tick(10);
    CS = 1'b0;
    channel_in = 8'h66;
    bits(16, SET2, FALLD);
    tick(2);
    CS = 1'b1;
    tick(200);
    check("ign_valid", {63'd0, out_valid}, 64'd1);
    check("ign_data", out_data, SET1);
    check("ign_chan", {56'd0, out_channel}, 64'h55);
    check("ign_ovf", {63'd0, overflow}, 64'd0);
    out_ready = 1'b1;
    tick(1);
    tick(200);
    check("ign_one", {63'd0, out_valid}, 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
